log_arbiter: RTL
================

Name: log_arbiter

Overview:
- Shares one host-facing log readout stream between N logger event-log streams.
- Arbitration is round-robin with a bounded burst length per grant.
- Each forwarded entry is tagged with its source index, then registered onto a single output stream.
- Sits between the per-channel loggers' log ports and the host readout path (UART/SPI framer).

Parameters:
- N, 4, number of requesting log streams (N>=2).
- LDW, 50, log entry width (event bits + timestamp).
- BST, 8, maximum entries transferred per grant (BST>=1).
- IW, $clog2(N), source index width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- ctl_ena  input  1  arbitration enable; sampled only in IDLE.
- sti_tready  output  N  per-source ready.
- sti_tvalid  input  N  per-source valid.
- sti_tdata  input  N*LDW  per-source data; source i occupies bits [i*LDW +: LDW].
- sto_tready  input  1  output ready.
- sto_tvalid  output  1  output valid (registered).
- sto_tdata  output  IW+LDW  {source index, entry} (registered).
- arb_gnt  output  N  one-hot current grant; zero in IDLE.
- arb_bsy  output  1  high in BURST state.

Behaviour:
- Reset values:
  - state=IDLE, rr pointer=N-1 (first search starts at source 0), burst count=0.
  - sto_tvalid=0, sto_tdata=0, arb_gnt=0, arb_bsy=0, sti_tready=0.
- Output register ready: ord = ~sto_tvalid | sto_tready.
- IDLE:
  - If ctl_ena and any sti_tvalid: pick the first valid source at index ptr+1, ptr+2, ... modulo N.
  - Next cycle: state=BURST, gnt=picked, ptr=picked, count=0.
  - All sti_tready=0 in IDLE.
- BURST:
  - sti_tready[gnt]=ord; all other readies are 0.
  - Input transfer (sti_tvalid[gnt] & ord) loads sto_tdata={gnt, data} and sets sto_tvalid=1.
  - Each input transfer increments count.
  - Exit to IDLE next cycle when:
    - a transfer occurs with count==BST-1, or
    - sti_tvalid[gnt]==0 in a cycle (source drained).
  - No exit while sti_tvalid[gnt]=1 and ord=0 (backpressure holds the grant).
  - ctl_ena deassert during BURST does not cut the burst.
- Output:
  - sto_tvalid clears on an output transfer with no simultaneous load.
  - Simultaneous load and unload keeps sto_tvalid=1 with new data.
  - sto_tdata is stable while sto_tvalid & ~sto_tready.
- Timing:
  - Source valid at cycle t in IDLE: grant visible at t+1; input transfer at t+1 if ord; sto_tvalid at t+2.
  - Throughput is 1 entry/cycle within a burst, plus 1 arbitration bubble cycle between bursts.
- Fairness: a continuously valid source receives at most BST entries before every other valid source receives a grant.
- Wrap-around:
  - Pointer search wraps modulo N.
  - N not a power of two: indices >=N are never selected.
  - Count width is $clog2(BST+1); it never exceeds BST-1.
- Reset mid-burst: grant drops immediately (async), any pending output entry is discarded, sti_tready=0.

Decomposition:
- Shared logger include/package (alongside logger constants): default LDW, N, BST; state encoding IDLE=1'b0, BURST=1'b1.
- One sub-module, log_rr_pick (combinational):
  - Inputs: request vector, pointer.
  - Outputs: found flag, picked index.
  - Implementation: rotate, priority-encode, unrotate.

Test Plan:
- Single source: source 2 holds 3 entries (0xA, 0xB, 0xC), sto_tready=1.
  - Required: sto_tdata idx=2 with data A, B, C on consecutive cycles, first at t+2.
  - Then arb_gnt=0 and arb_bsy falls.
- Burst limit: BST=8, source 0 has 20 entries, others idle.
  - Required: bursts of 8, 8, 4, with exactly one bubble cycle between bursts.
- Round-robin: all 4 sources continuously valid.
  - Required: grant order 0,1,2,3,0, each grant 8 entries, tags match the source.
- Backpressure: sto_tready=0 for 5 cycles mid-burst.
  - Required: sto_tdata stable; sti_tready[gnt]=0; no entry lost or duplicated; burst resumes and count continues.
- Enable and drain: ctl_ena=0 with sources valid.
  - Required: no grant.
  - Source 1 valid deasserts after 2 entries: IDLE next cycle, then source 2 is granted.
- Reset mid-burst: rst pulse during the burst from source 3.
  - Required: all outputs are at reset values the same cycle.
  - After release, the first grant goes to the lowest-index valid source.

Source files
------------

// File: rtl/log_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// log_arbiter_pkg
//   Shared logger constants for the log readout arbiter: default stream
//   count, log entry width (event bits + timestamp), burst limit per grant
//   and the arbiter state encoding.
//   No ports; imported by log_arbiter_if, log_rr_pick and log_arbiter.
// ---------------------------------------------------------------------------
package log_arbiter_pkg;

  // Default number of logger streams sharing the readout path.
  localparam int LOG_N_DEF   = 4;
  // Default log entry width: event bits plus timestamp.
  localparam int LOG_LDW_DEF = 50;
  // Default maximum entries forwarded per grant.
  localparam int LOG_BST_DEF = 8;

  // Arbiter state: IDLE searches for a requester, BURST forwards its entries.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/log_arbiter_if.sv
// ---------------------------------------------------------------------------
// log_arbiter_if
//   Bundles the arbiter's control, per-source input streams, the shared
//   output stream and the grant status.
//   Parameters: N streams, LDW entry width; IW = $clog2(N) source tag width.
//   Signals:
//     ctl_ena     arbitration enable (sampled by the arbiter in IDLE)
//     sti_tready  N      per-source ready (arbiter -> sources)
//     sti_tvalid  N      per-source valid
//     sti_tdata   N*LDW  per-source entry, source i at [i*LDW +: LDW]
//     sto_tready  1      host ready
//     sto_tvalid  1      output valid
//     sto_tdata   IW+LDW {source index, entry}
//     arb_gnt     N      one-hot current grant
//     arb_bsy     1      burst in progress
//   Modports: slave = arbiter side, master = loggers/host side.
// ---------------------------------------------------------------------------
interface log_arbiter_if import log_arbiter_pkg::*; #(
  parameter int N   = LOG_N_DEF,
  parameter int LDW = LOG_LDW_DEF
);
  localparam int IW = $clog2(N);

  logic                ctl_ena;
  logic [N-1:0]        sti_tready;
  logic [N-1:0]        sti_tvalid;
  logic [N*LDW-1:0]    sti_tdata;
  logic                sto_tready;
  logic                sto_tvalid;
  logic [IW+LDW-1:0]   sto_tdata;
  logic [N-1:0]        arb_gnt;
  logic                arb_bsy;

  modport slave (
    input  ctl_ena,
    input  sti_tvalid,
    input  sti_tdata,
    input  sto_tready,
    output sti_tready,
    output sto_tvalid,
    output sto_tdata,
    output arb_gnt,
    output arb_bsy
  );

  modport master (
    output ctl_ena,
    output sti_tvalid,
    output sti_tdata,
    output sto_tready,
    input  sti_tready,
    input  sto_tvalid,
    input  sto_tdata,
    input  arb_gnt,
    input  arb_bsy
  );

endinterface

// File: rtl/log_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// log_rr_pick
//   Combinational round-robin selector. Searches the request vector starting
//   at the index just after ptr, wrapping modulo N, and returns the first
//   requester found.
//   Ports:
//     req    in  N   request vector
//     ptr    in  IW  last granted index (search starts at ptr+1)
//     found  out 1   at least one request is set
//     idx    out IW  selected index (always < N; 0 when nothing found)
//   Implementation: rotate so bit 0 is index ptr+1, priority-encode the
//   lowest set bit, then add the offset back onto ptr+1 modulo N. The modulo
//   keeps indices >= N unreachable when N is not a power of two.
// ---------------------------------------------------------------------------
module log_rr_pick import log_arbiter_pkg::*; #(
  parameter int N  = LOG_N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] off_s;
  logic          hit_s;

  // Rotate requests so that rot_s[k] is the request at (ptr+1+k) mod N.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < N; k++) begin
      rot_s[k] = req[IW'((int'(ptr) + 1 + k) % N)];
    end
  end

  // Priority-encode the rotated vector: lowest set bit wins, scanned high to low.
  always_comb begin
    hit_s = 1'b0;
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        hit_s = 1'b1;
        off_s = IW'(k);
      end else begin
        hit_s = hit_s;
        off_s = off_s;
      end
    end
  end

  // Undo the rotation to get the absolute source index.
  always_comb begin
    found = hit_s;
    if (hit_s) begin
      idx = IW'((int'(ptr) + 1 + int'(off_s)) % N);
    end else begin
      idx = '0;
    end
  end

endmodule

// File: rtl/log_arbiter.sv
// ---------------------------------------------------------------------------
// log_arbiter
//   Shares one host log readout stream between N logger event-log streams.
//   Round-robin grant with at most BST entries per grant; each forwarded
//   entry is tagged with its source index and held in a single output
//   register until the host takes it.
//   Parameters: N streams (>=2), LDW entry width, BST burst limit (>=1).
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   log_arbiter_if.slave: ctl_ena, sti_* inputs, sto_* output
//           stream, arb_gnt one-hot grant, arb_bsy burst flag.
//   Behaviour summary:
//     IDLE  : with ctl_ena and any valid source, pick the next requester
//             after the pointer; BURST starts the following cycle.
//     BURST : only the granted source sees ready (= output register ready).
//             Leaves after the BST-th transfer or as soon as the granted
//             source drops valid. Backpressure holds the grant.
//   The IDLE cycle between bursts is the arbitration bubble.
// ---------------------------------------------------------------------------
module log_arbiter import log_arbiter_pkg::*; #(
  parameter int N   = LOG_N_DEF,
  parameter int LDW = LOG_LDW_DEF,
  parameter int BST = LOG_BST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  log_arbiter_if.slave     bus
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BST - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(N - 1);

  // Arbiter state. ptr_r is both the round-robin pointer and, in BURST,
  // the index of the granted source.
  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     ptr_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic [N-1:0]      gnt_r;
  logic [N-1:0]      gnt_nxt_s;

  // Output stream register.
  logic              sto_tvalid_r;
  logic [IW+LDW-1:0] sto_tdata_r;

  // Handshake decode.
  logic              ord_s;
  logic              cur_vld_s;
  logic [LDW-1:0]    cur_data_s;
  logic              in_xfer_s;
  logic              cnt_last_s;
  logic [N-1:0]      sti_tready_s;

  // Round-robin search result.
  logic              pick_found_s;
  logic [IW-1:0]     pick_idx_s;

  // One-hot decode of a source index.
  function automatic logic [N-1:0] idx_onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  log_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (bus.sti_tvalid),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // State register: async reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_RST;
      cnt_r   <= '0;
      gnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      gnt_r   <= gnt_nxt_s;
    end
  end

  // Handshake decode: readiness of the output register and granted-source transfer.
  always_comb begin
    ord_s      = ~sto_tvalid_r | bus.sto_tready;
    cur_vld_s  = bus.sti_tvalid[ptr_r];
    cur_data_s = bus.sti_tdata[int'(ptr_r) * LDW +: LDW];
    cnt_last_s = (cnt_r == CNT_LAST);
    if (state_r == ST_BURST) begin
      in_xfer_s    = cur_vld_s & ord_s;
      sti_tready_s = gnt_r & {N{ord_s}};
    end else begin
      in_xfer_s    = 1'b0;
      sti_tready_s = '0;
    end
  end

  // Next-state logic: grant selection in IDLE, burst termination in BURST.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ctl_ena && pick_found_s) begin
          state_nxt_s = ST_BURST;
          ptr_nxt_s   = pick_idx_s;
          gnt_nxt_s   = idx_onehot(pick_idx_s);
          cnt_nxt_s   = '0;
        end else begin
          gnt_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end
      end
      ST_BURST: begin
        // A drained source ends the burst even without a transfer; the
        // BST-th transfer ends it too. ctl_ena is deliberately ignored here.
        if (!cur_vld_s || (in_xfer_s && cnt_last_s)) begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end else if (in_xfer_s) begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end else begin
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output register: load on input transfer, clear on unload, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tvalid_r <= 1'b0;
      sto_tdata_r  <= '0;
    end else if (in_xfer_s) begin
      sto_tvalid_r <= 1'b1;
      sto_tdata_r  <= {ptr_r, cur_data_s};
    end else if (bus.sto_tready) begin
      sto_tvalid_r <= 1'b0;
    end
  end

  assign bus.sti_tready = sti_tready_s;
  assign bus.sto_tvalid = sto_tvalid_r;
  assign bus.sto_tdata  = sto_tdata_r;
  assign bus.arb_gnt    = gnt_r;
  assign bus.arb_bsy    = (state_r == ST_BURST);

endmodule
